// File: rtl/csr_trap_ctrl_pkg.sv
// csr_trap_ctrl_pkg: CSR addresses, bit positions, PC-mux codes and FSM states for csr_trap_ctrl
package csr_trap_ctrl_pkg;
    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MIE     = 12'h304;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MIP     = 12'h344;
    localparam int BIT_MIE  = 3;
    localparam int BIT_MPIE = 7;
    localparam int BIT_MEIE = 11;
    localparam int BIT_MEIP = 11;
    localparam logic [31:0] CAUSE_EXT_DEF = 32'h8000_000B;
    localparam logic [2:0] SEL_MTVEC = 3'd4;
    localparam logic [2:0] SEL_MEPC  = 3'd5;
    typedef enum logic [2:0] {IDLE = 3'b001, PEND = 3'b010, TRAP = 3'b100} state_e;
    function automatic logic [31:0] align4(input logic [31:0] v);
        return v & ~32'd3;
    endfunction
endpackage

// File: rtl/csr_trap_ctrl_intr_sync.sv
// intr_sync: multi-stage synchroniser for an async level plus rising-edge pulse
//   clk, rst (async, active-high) | async_in: raw level | level: synced level | rise: 1-cycle edge pulse
module intr_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d;
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        level  = sync_q[STAGES-1];
        prev_d = level;
        rise   = level & ~prev_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end
endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: machine-mode CSRs and external-interrupt trap controller driving the PC-source mux
//   CLK, RST (async, active-high) | INTR: async irq level | INSTR_DONE: retire pulse
//   PC_NEXT: next PC | BASE_SEL: decoder PC select | MRET_EXEC, CSR_WE/ADDR/WD: retiring-instr controls
//   CSR_RD: comb read data | MTVEC, MEPC: mux inputs 4/5 | PC_SEL: mux select | INT_TAKEN: trap pulse
module csr_trap_ctrl
    import csr_trap_ctrl_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] CAUSE_EXT   = CAUSE_EXT_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INTR,
    input  logic        INSTR_DONE,
    input  logic [31:0] PC_NEXT,
    input  logic [2:0]  BASE_SEL,
    input  logic        MRET_EXEC,
    input  logic        CSR_WE,
    input  logic [11:0] CSR_ADDR,
    input  logic [31:0] CSR_WD,
    output logic [31:0] CSR_RD,
    output logic [31:0] MTVEC,
    output logic [31:0] MEPC,
    output logic [2:0]  PC_SEL,
    output logic        INT_TAKEN
);
    state_e state_q, state_d;
    logic pending_q, pending_d;
    logic mie_q, mie_d, mpie_q, mpie_d, meie_q, meie_d;
    logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic intr_level, intr_rise;
    logic wr, mret, take;
    logic wr_mstatus, wr_mie, wr_mtvec, wr_mepc, wr_mcause;

    intr_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (CLK),
        .rst      (RST),
        .async_in (INTR),
        .level    (intr_level),
        .rise     (intr_rise)
    );

    always_comb begin
        wr         = CSR_WE & INSTR_DONE;
        mret       = INSTR_DONE & MRET_EXEC;
        // MRET wins over trap entry; the interrupt stays pending for the next boundary
        take       = (state_q == PEND) & INSTR_DONE & mie_q & meie_q & ~MRET_EXEC;
        wr_mstatus = wr & (CSR_ADDR == ADDR_MSTATUS);
        wr_mie     = wr & (CSR_ADDR == ADDR_MIE);
        wr_mtvec   = wr & (CSR_ADDR == ADDR_MTVEC);
        wr_mepc    = wr & (CSR_ADDR == ADDR_MEPC);
        wr_mcause  = wr & (CSR_ADDR == ADDR_MCAUSE);
        // a fresh edge on the entry cycle must not be lost, so set beats clear
        pending_d  = intr_rise | (pending_q & ~take);
        state_d    = (state_q == IDLE) ? (pending_q ? PEND : IDLE) :
                     (state_q == PEND) ? (take ? TRAP : PEND) : IDLE;
        mie_d      = take ? 1'b0 : mret ? mpie_q : wr_mstatus ? CSR_WD[BIT_MIE] : mie_q;
        mpie_d     = take ? mie_q : mret ? 1'b1 : wr_mstatus ? CSR_WD[BIT_MPIE] : mpie_q;
        meie_d     = wr_mie ? CSR_WD[BIT_MEIE] : meie_q;
        mtvec_d    = wr_mtvec ? align4(CSR_WD) : mtvec_q;
        mepc_d     = take ? align4(PC_NEXT) : wr_mepc ? align4(CSR_WD) : mepc_q;
        mcause_d   = take ? CAUSE_EXT : wr_mcause ? CSR_WD : mcause_q;
        CSR_RD     = (CSR_ADDR == ADDR_MSTATUS) ? (32'(mie_q) << BIT_MIE) | (32'(mpie_q) << BIT_MPIE) :
                     (CSR_ADDR == ADDR_MIE)     ? 32'(meie_q) << BIT_MEIE :
                     (CSR_ADDR == ADDR_MTVEC)   ? mtvec_q :
                     (CSR_ADDR == ADDR_MEPC)    ? mepc_q :
                     (CSR_ADDR == ADDR_MCAUSE)  ? mcause_q :
                     (CSR_ADDR == ADDR_MIP)     ? 32'(intr_level) << BIT_MEIP : 32'd0;
        INT_TAKEN  = (state_q == TRAP);
        PC_SEL     = INT_TAKEN ? SEL_MTVEC : mret ? SEL_MEPC : BASE_SEL;
        MTVEC      = mtvec_q;
        MEPC       = mepc_q;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            mie_q     <= 1'b0;
            mpie_q    <= 1'b0;
            meie_q    <= 1'b0;
            mtvec_q   <= '0;
            mepc_q    <= '0;
            mcause_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mie_q     <= mie_d;
            mpie_q    <= mpie_d;
            meie_q    <= meie_d;
            mtvec_q   <= mtvec_d;
            mepc_q    <= mepc_d;
            mcause_q  <= mcause_d;
        end
    end
endmodule
